// File: rtl/mips_alu_pkg.sv
// Shared definitions for the multicycle MIPS ALU: the 3-bit alucontrol encoding.
package mips_alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 3'b000;
  localparam alu_op_t ALU_OR   = 3'b001;
  localparam alu_op_t ALU_ADD  = 3'b010;
  localparam alu_op_t ALU_RSV  = 3'b011;
  localparam alu_op_t ALU_ANDN = 3'b100;
  localparam alu_op_t ALU_ORN  = 3'b101;
  localparam alu_op_t ALU_SUB  = 3'b110;
  localparam alu_op_t ALU_SLT  = 3'b111;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
// The overflow flag exists only when MIPS_ALU_OVERFLOW_EN is defined.
interface mips_alu_if #(parameter int WIDTH = 32);
  import mips_alu_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_t          f;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [WIDTH-1:0] aluout;
`ifdef MIPS_ALU_OVERFLOW_EN
  logic             overflow;

  modport master (output a, b, f, input y, zero, aluout, overflow);
  modport slave  (input a, b, f, output y, zero, aluout, overflow);
`else
  modport master (output a, b, f, input y, zero, aluout);
  modport slave  (input a, b, f, output y, zero, aluout);
`endif

endinterface

// File: rtl/mips_alu_addsub.sv
// Single adder shared by ADD, SUB and SLT: computes a + (b ^ {WIDTH{sub}}) + sub.
module mips_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff      = b ^ {WIDTH{sub}};
  assign {cout, sum}  = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
  // Signed overflow: both adder inputs share a sign that the sum does not.
  assign ovf          = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// Combinational 32-bit MIPS ALU with zero flag and the registered ALUOut copy.
// Optional signed overflow flag enabled by defining MIPS_ALU_OVERFLOW_EN.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32  // must match the WIDTH of the connected interface
) (
  input  logic       clk,
  input  logic       reset,
  mips_alu_if.slave  bus
);

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_aluout;
  logic             w_unused_cout;

  assign w_sub = (bus.f == ALU_SUB) || (bus.f == ALU_SLT);

  mips_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (bus.a),
    .b    (bus.b),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  assign w_unused_cout = w_cout;

  // Sign of the difference corrected by overflow gives the true signed compare.
  assign w_lt = w_sum[WIDTH-1] ^ w_ovf;

  // NOTE: default assignment first so every path drives w_y and no latch is inferred.
  always_comb begin
    w_y = '0;
    case (bus.f)
      ALU_AND:  w_y = bus.a & bus.b;
      ALU_OR:   w_y = bus.a | bus.b;
      ALU_ADD:  w_y = w_sum;
      ALU_ANDN: w_y = bus.a & ~bus.b;
      ALU_ORN:  w_y = bus.a | ~bus.b;
      ALU_SUB:  w_y = w_sum;
      ALU_SLT:  w_y = {{(WIDTH-1){1'b0}}, w_lt};
      default:  w_y = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_aluout <= '0;
    else       r_aluout <= w_y;
  end

  assign bus.y      = w_y;
  assign bus.zero   = ~|w_y;
  assign bus.aluout = r_aluout;

`ifdef MIPS_ALU_OVERFLOW_EN
  always_comb begin
    bus.overflow = 1'b0;
    if (bus.f == ALU_ADD || bus.f == ALU_SUB) bus.overflow = w_ovf;
  end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Directed self-checking bench for mips_alu; overflow vectors run when MIPS_ALU_OVERFLOW_EN is defined.
module tb_mips_alu;
  import mips_alu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mips_alu_if #(.WIDTH(32)) bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; combinational outputs are sampled 1 ns later.
  task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.f = op;
    bus.a = a;
    bus.b = b;
    #1;
  endtask

  task automatic test_reset;
    bus.f = ALU_ADD;
    bus.a = 32'd1;
    bus.b = 32'd2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluout !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_aluout got=%h exp=%h", bus.aluout, 32'd0);
    end
    n_checks++;
    if (bus.y !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_y_comb got=%h exp=%h", bus.y, 32'd3);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    drive(ALU_ADD, 32'd5, 32'd7);
    n_checks++;
    if (bus.y !== 32'd12 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_5_7 got y=%h zero=%b exp y=%h zero=0", bus.y, bus.zero, 32'd12);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluout !== 32'd12) begin
      n_fail++;
      $display("FAIL add_aluout got=%h exp=%h", bus.aluout, 32'd12);
    end
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    n_checks++;
    if (bus.y !== 32'd0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap got y=%h zero=%b exp y=0 zero=1", bus.y, bus.zero);
    end
  endtask

  task automatic test_sub;
    drive(ALU_SUB, 32'h1234, 32'h1234);
    n_checks++;
    if (bus.y !== 32'd0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_equal got y=%h zero=%b exp y=0 zero=1", bus.y, bus.zero);
    end
    drive(ALU_SUB, 32'd3, 32'd5);
    n_checks++;
    if (bus.y !== 32'hFFFF_FFFE || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_3_5 got y=%h zero=%b exp y=fffffffe zero=0", bus.y, bus.zero);
    end
    drive(ALU_SUB, 32'h8000_0000, 32'd1);
    n_checks++;
    if (bus.y !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL sub_wrap got=%h exp=7fffffff", bus.y);
    end
  endtask

  task automatic test_logic;
    alu_op_t     ops [4] = '{ALU_AND, ALU_OR, ALU_ANDN, ALU_ORN};
    logic [31:0] exp [4] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h00F0_00F0, 32'hF0FF_F0FF};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
      n_checks++;
      if (bus.y !== exp[i] || bus.zero !== 1'b0) begin
        n_fail++;
        $display("FAIL logic_f%0d got y=%h zero=%b exp y=%h zero=0", ops[i], bus.y, bus.zero, exp[i]);
      end
    end
  endtask

  task automatic test_slt;
    logic [31:0] va  [4] = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd5};
    logic [31:0] vb  [4] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] exp [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    logic        ez  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(ALU_SLT, va[i], vb[i]);
      n_checks++;
      if (bus.y !== exp[i] || bus.zero !== ez[i]) begin
        n_fail++;
        $display("FAIL slt_%0d got y=%h zero=%b exp y=%h zero=%b", i, bus.y, bus.zero, exp[i], ez[i]);
      end
    end
  endtask

  task automatic test_reserved;
    drive(ALU_RSV, 32'h1234_5678, 32'h0000_00FF);
    n_checks++;
    if (bus.y !== 32'd0 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved got y=%h zero=%b exp y=0 zero=1", bus.y, bus.zero);
    end
  endtask

  task automatic test_reset_mid_run;
    drive(ALU_ADD, 32'h50, 32'h05);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluout !== 32'h55) begin
      n_fail++;
      $display("FAIL midrst_preload got=%h exp=%h", bus.aluout, 32'h55);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.aluout !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_async_clear got=%h exp=0", bus.aluout);
    end
    drive(ALU_ADD, 32'd1, 32'd1);
    n_checks++;
    if (bus.y !== 32'd2) begin
      n_fail++;
      $display("FAIL midrst_y_tracks got=%h exp=2", bus.y);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluout !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_held got=%h exp=0", bus.aluout);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.aluout !== 32'd2) begin
      n_fail++;
      $display("FAIL midrst_release_load got=%h exp=2", bus.aluout);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [3] = '{32'd30, 32'd10, 32'd1};
    alu_op_t     ops [3] = '{ALU_ADD, ALU_SUB, ALU_SLT};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 32'd10 * (i == 2 ? 32'd0 : 32'd2), 32'd10 * (i == 2 ? 32'd1 : 32'd1));
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.aluout !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, bus.aluout, exp[i]);
      end
    end
  endtask

`ifdef MIPS_ALU_OVERFLOW_EN
  task automatic test_overflow;
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    n_checks++;
    if (bus.y !== 32'h8000_0000 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_add got y=%h ovf=%b exp y=80000000 ovf=1", bus.y, bus.overflow);
    end
    drive(ALU_SUB, 32'h8000_0000, 32'd1);
    n_checks++;
    if (bus.y !== 32'h7FFF_FFFF || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sub got y=%h ovf=%b exp y=7fffffff ovf=1", bus.y, bus.overflow);
    end
    drive(ALU_AND, 32'h7FFF_FFFF, 32'h8000_0000);
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_and got=%b exp=0", bus.overflow);
    end
    drive(ALU_ADD, 32'd5, 32'd7);
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_add_none got=%b exp=0", bus.overflow);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_slt();
    test_reserved();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MIPS_ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
